scheduler: RTL and testbench

Per-core control FSM for the compute core. It drives `core_state` to sequence the fetcher, decoder, per-thread LSUs, ALUs, PC units and register files through one instruction at a time. It waits on the fetcher and on every active thread's LSU, then commits a single core-wide PC from the per-thread PC units. The core runs one block; `done` reports block completion to the dispatcher.

---
 rtl/gpu_pkg.sv | 40 ++++
 rtl/pc_select.sv | 34 +++
 rtl/scheduler.sv | 106 ++++++++++
 tb/tb_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the compute core: scheduler, fetcher, LSU and PC-unit states.
// Every block that decodes another block's state imports it from here.
package gpu_pkg;

    localparam int CORE_STATE_W    = 3;
    localparam int FETCHER_STATE_W = 3;
    localparam int LSU_STATE_W     = 2;

    typedef enum logic [CORE_STATE_W-1:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [FETCHER_STATE_W-1:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

    typedef enum logic [LSU_STATE_W-1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

    // An LSU holds up the core only while its access is still outstanding.
    function automatic logic lsu_busy(input logic [LSU_STATE_W-1:0] raw);
        lsu_state_t st;
        st = lsu_state_t'(raw);
        return (st == LSU_REQUESTING) || (st == LSU_WAITING);
    endfunction

endpackage

// File: rtl/pc_select.sv
// Picks the next PC from the lowest-index active lane and flags whether any
// other active lane disagrees. An empty mask falls back to lane 0, never mismatching.
module pc_select #(
    parameter int LANES     = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic [LANES-1:0]           thread_mask_i,
    input  logic [ADDR_BITS*LANES-1:0] next_pc_i,
    output logic [ADDR_BITS-1:0]       selected_pc_o,
    output logic                       mismatch_o
);

    logic found;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        selected_pc_o = next_pc_i[ADDR_BITS-1:0];
        found         = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (thread_mask_i[i] && !found) begin
                selected_pc_o = next_pc_i[i*ADDR_BITS +: ADDR_BITS];
                found         = 1'b1;
            end
        end

        mismatch_o = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (thread_mask_i[i] && (next_pc_i[i*ADDR_BITS +: ADDR_BITS] != selected_pc_o)) begin
                mismatch_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scheduler.sv
// Per-core control FSM: steps the core through FETCH..UPDATE for one instruction
// at a time, waits on the fetcher and active LSUs, and commits a single core-wide PC.
module scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [THREADS_PER_BLOCK-1:0]                       thread_mask,
    input  logic                                               decoded_ret,
    input  logic [FETCHER_STATE_W-1:0]                         fetcher_state,
    input  logic [LSU_STATE_W*THREADS_PER_BLOCK-1:0]           lsu_state,
    input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [CORE_STATE_W-1:0]                            core_state,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
    output logic                                               done,
    output logic                                               pc_diverged
);

    core_state_t                      state_q, state_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
    logic                             done_q, done_d;
    logic                             diverged_q, diverged_d;

    logic [PROGRAM_MEM_ADDR_BITS-1:0] selected_pc;
    logic                             pc_mismatch;
    logic                             lanes_busy;

    pc_select #(
        .LANES     (THREADS_PER_BLOCK),
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS)
    ) u_pc_select (
        .thread_mask_i (thread_mask),
        .next_pc_i     (next_pc),
        .selected_pc_o (selected_pc),
        .mismatch_o    (pc_mismatch)
    );

    // Inactive lanes may sit in any LSU state; only active ones can stall WAIT.
    always_comb begin
        lanes_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_mask[i] && lsu_busy(lsu_state[i*LSU_STATE_W +: LSU_STATE_W])) begin
                lanes_busy = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        done_d     = done_q;
        diverged_d = diverged_q;

        unique case (state_q)
            CORE_IDLE: begin
                if (start) state_d = CORE_FETCH;
            end
            CORE_FETCH: begin
                if (fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
            end
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT: begin
                if (!lanes_busy) state_d = CORE_EXECUTE;
            end
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                if (pc_mismatch) diverged_d = 1'b1;
                if (decoded_ret) begin
                    state_d = CORE_DONE;
                    done_d  = 1'b1;
                end else begin
                    pc_d    = selected_pc;
                    state_d = CORE_FETCH;
                end
            end
            CORE_DONE: state_d = CORE_DONE;
            default:   state_d = CORE_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CORE_IDLE;
            pc_q       <= '0;
            done_q     <= 1'b0;
            diverged_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            done_q     <= done_d;
            diverged_q <= diverged_d;
        end
    end

    assign core_state  = state_q;
    assign current_pc  = pc_q;
    assign done        = done_q;
    assign pc_diverged = diverged_q;

endmodule

// File: tb/tb_scheduler.sv
// Self-checking bench for scheduler: a table of per-instruction vectors drives the
// fetcher/LSU/PC inputs while expected per-cycle outputs flow through a scoreboard queue.
module tb_scheduler;
    import gpu_pkg::*;

    localparam int T = 4;
    localparam int A = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [T-1:0]   thread_mask;
    logic           decoded_ret;
    logic [2:0]     fetcher_state;
    logic [2*T-1:0] lsu_state;
    logic [A*T-1:0] next_pc;
    logic [2:0]     core_state;
    logic [A-1:0]   current_pc;
    logic           done;
    logic           pc_diverged;

    scheduler #(
        .THREADS_PER_BLOCK     (T),
        .PROGRAM_MEM_ADDR_BITS (A)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_mask   (thread_mask),
        .decoded_ret   (decoded_ret),
        .fetcher_state (fetcher_state),
        .lsu_state     (lsu_state),
        .next_pc       (next_pc),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .done          (done),
        .pc_diverged   (pc_diverged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [T-1:0]   mask;
        int             fetch_cycles;
        int             lane2_hold;
        logic [A*T-1:0] npc;
        logic           ret;
        logic           start_level;
        int             exp_wait;
        logic [A-1:0]   exp_pc;
        logic           exp_div;
    } vec_t;

    typedef struct {
        logic [2:0]   state;
        logic [A-1:0] pc;
        logic         div;
        logic         dn;
    } exp_t;

    vec_t   vecs[10];
    vec_t   vreset;
    exp_t   sb[$];
    int     checks   = 0;
    int     failures = 0;
    logic [A-1:0] prev_pc;
    logic         prev_div;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, " core_state"},  32'(core_state),  32'(e.state));
        check({tag, " current_pc"},  32'(current_pc),  32'(e.pc));
        check({tag, " pc_diverged"}, 32'(pc_diverged), 32'(e.div));
        check({tag, " done"},        32'(done),        32'(e.dn));
    endtask

    function automatic exp_t mk(input logic [2:0] s, input logic [A-1:0] pc, input logic dv, input logic dn);
        exp_t e;
        e.state = s;
        e.pc    = pc;
        e.div   = dv;
        e.dn    = dn;
        return e;
    endfunction

    // Entered with the DUT in its first FETCH cycle; leaves it in the cycle after UPDATE.
    task automatic run_instr(input int idx, input vec_t v);
        int   f;
        int   w;
        int   len;
        exp_t e;
        f   = v.fetch_cycles;
        w   = v.exp_wait;
        len = f + w + 4;
        for (int k = 0; k <= len; k++) begin
            if (k < f)               e = mk(CORE_FETCH,   prev_pc, prev_div, 1'b0);
            else if (k == f)         e = mk(CORE_DECODE,  prev_pc, prev_div, 1'b0);
            else if (k == f + 1)     e = mk(CORE_REQUEST, prev_pc, prev_div, 1'b0);
            else if (k < f + 2 + w)  e = mk(CORE_WAIT,    prev_pc, prev_div, 1'b0);
            else if (k == f + 2 + w) e = mk(CORE_EXECUTE, prev_pc, prev_div, 1'b0);
            else if (k == f + 3 + w) e = mk(CORE_UPDATE,  prev_pc, prev_div, 1'b0);
            else e = mk(v.ret ? CORE_DONE : CORE_FETCH, v.exp_pc, v.exp_div, v.ret);
            sb.push_back(e);
        end

        thread_mask = v.mask;
        next_pc     = v.npc;
        decoded_ret = v.ret;
        start       = v.start_level;
        for (int k = 0; k <= len; k++) begin
            e = sb.pop_front();
            check_outputs($sformatf("v%0d c%0d", idx, k), e);
            if (k == len) break;
            fetcher_state = (k == f - 1) ? FETCHER_FETCHED : FETCHER_FETCHING;
            if (k == f + 1) begin
                lsu_state = 8'h55;
            end else if (k >= f + 2) begin
                lsu_state      = 8'hFF;
                lsu_state[5:4] = (k < f + 2 + v.lane2_hold) ? LSU_WAITING : LSU_DONE;
            end else begin
                lsu_state = 8'h00;
            end
            step();
        end
        start    = 1'b0;
        prev_pc  = v.exp_pc;
        prev_div = v.exp_div;
    endtask

    initial begin
        //          mask     F  hold  next_pc {l3,l2,l1,l0}          ret  start W  pc      div
        vecs[0] = '{4'b1111, 1, 0, {8'd1,   8'd1,  8'd1,  8'd1},   1'b0, 1'b0, 1, 8'd1,   1'b0};
        vecs[1] = '{4'b1111, 3, 5, {8'd2,   8'd2,  8'd2,  8'd2},   1'b0, 1'b1, 6, 8'd2,   1'b0};
        vecs[2] = '{4'b1011, 1, 5, {8'd3,   8'd3,  8'd3,  8'd3},   1'b0, 1'b0, 1, 8'd3,   1'b0};
        vecs[3] = '{4'b0000, 2, 5, {8'd50,  8'd60, 8'd70, 8'd4},   1'b0, 1'b0, 1, 8'd4,   1'b0};
        vecs[4] = '{4'b1111, 1, 0, {8'hFF,  8'hFF, 8'hFF, 8'hFF},  1'b0, 1'b0, 1, 8'hFF,  1'b0};
        vecs[5] = '{4'b1111, 2, 0, {8'h00,  8'h00, 8'h00, 8'h00},  1'b0, 1'b1, 1, 8'h00,  1'b0};
        vecs[6] = '{4'b1100, 1, 0, {8'd9,   8'd9,  8'd3,  8'd3},   1'b0, 1'b0, 1, 8'd9,   1'b0};
        vecs[7] = '{4'b1100, 1, 0, {8'd10,  8'd9,  8'd3,  8'd3},   1'b0, 1'b0, 1, 8'd9,   1'b1};
        vecs[8] = '{4'b0001, 1, 2, {8'd1,   8'd2,  8'd3,  8'd7},   1'b0, 1'b0, 1, 8'd7,   1'b1};
        vecs[9] = '{4'b0001, 1, 0, {8'd7,   8'd7,  8'd7,  8'd7},   1'b1, 1'b0, 1, 8'd7,   1'b1};
        vreset  = '{4'b1111, 1, 0, {8'd10,  8'd9,  8'd9,  8'd9},   1'b0, 1'b0, 1, 8'd9,   1'b1};

        reset         = 1'b1;
        start         = 1'b0;
        thread_mask   = 4'b1111;
        decoded_ret   = 1'b0;
        fetcher_state = FETCHER_IDLE;
        lsu_state     = 8'h00;
        next_pc       = '0;
        prev_pc       = 8'd0;
        prev_div      = 1'b0;

        step();
        reset = 1'b0;
        check_outputs("reset", mk(CORE_IDLE, 8'd0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            step();
            check_outputs($sformatf("idle hold %0d", i), mk(CORE_IDLE, 8'd0, 1'b0, 1'b0));
        end

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) run_instr(i, vecs[i]);

        // DONE is terminal: start pulses must not move it.
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            step();
            check_outputs($sformatf("done hold %0d", i), mk(CORE_DONE, 8'd7, 1'b1, 1'b1));
        end
        start = 1'b0;

        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outputs("reset from done", mk(CORE_IDLE, 8'd0, 1'b0, 1'b0));
        prev_pc  = 8'd0;
        prev_div = 1'b0;

        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(10, vreset);

        // Walk the next instruction into WAIT with lane 2 stalled, then reset there.
        fetcher_state = FETCHER_FETCHED;
        step();
        fetcher_state = FETCHER_FETCHING;
        step();
        lsu_state = 8'h55;
        step();
        check_outputs("mid wait 0", mk(CORE_WAIT, 8'd9, 1'b1, 1'b0));
        lsu_state = 8'hEF;
        step();
        check_outputs("mid wait 1", mk(CORE_WAIT, 8'd9, 1'b1, 1'b0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outputs("reset in wait", mk(CORE_IDLE, 8'd0, 1'b0, 1'b0));
        step();
        check_outputs("idle after reset", mk(CORE_IDLE, 8'd0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
